// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory with little-endian words
//
// Receives a 16-bit little-endian word count followed by count*4 data bytes.
// Each group of four data bytes is assembled into one word, least significant
// byte first. Each word is then written to instruction memory at
// BASE_ADDR + 4*word_idx. cpu_hold stays high for the whole session, so fetch
// never sees partially loaded memory.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a session (ignored while busy)
//   rx_data/valid/ready   incoming byte handshake; a byte moves on valid & ready
//   mem_we/addr/wdata     one-cycle write strobe with byte address and word
//   cpu_hold, busy        high while a session is in progress
//   done, error           sticky result of the last session (error: count > DEPTH)
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int WW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_n;
    logic [15:0] count, count_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic [WW-1:0] word_idx, word_idx_n;
    // Only the first three bytes need buffering; the fourth goes straight
    // into mem_wdata on the edge that accepts it.
    logic [23:0] wbuf, wbuf_n;
    logic        mem_we_n;
    logic [31:0] mem_addr_n, mem_wdata_n;
    logic        cpu_hold_n, busy_n, done_n, error_n;
    logic [15:0] len;
    logic        accept;

    // rx_ready is a pure decode of the state register, so it is glitch-free
    // and reads 0 in reset.
    assign rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
    assign accept   = rx_valid && rx_ready;
    assign len      = {rx_data, count[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            byte_idx  <= '0;
            word_idx  <= '0;
            wbuf      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            byte_idx  <= byte_idx_n;
            word_idx  <= word_idx_n;
            wbuf      <= wbuf_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            cpu_hold  <= cpu_hold_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        byte_idx_n  = byte_idx;
        word_idx_n  = word_idx;
        wbuf_n      = wbuf;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cpu_hold_n  = cpu_hold;
        busy_n      = busy;
        done_n      = done;
        error_n     = error;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_LEN_LO;
                    count_n    = '0;
                    done_n     = 1'b0;
                    error_n    = 1'b0;
                    busy_n     = 1'b1;
                    cpu_hold_n = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    count_n[7:0] = rx_data;
                    state_n      = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    count_n = len;
                    if (len == 16'd0) begin
                        state_n = S_DONE;
                    end else if (32'(len) > DEPTH) begin
                        state_n = S_ERR;
                    end else begin
                        state_n    = S_DATA;
                        byte_idx_n = '0;
                        word_idx_n = '0;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_idx == 2'd3) begin
                        // Registering the strobe here makes mem_we visible
                        // during the WRITE cycle itself.
                        mem_we_n    = 1'b1;
                        mem_wdata_n = {rx_data, wbuf};
                        mem_addr_n  = BASE_ADDR + (32'(word_idx) << 2);
                        byte_idx_n  = '0;
                        state_n     = S_WRITE;
                    end else begin
                        case (byte_idx)
                            2'd0:    wbuf_n[7:0]   = rx_data;
                            2'd1:    wbuf_n[15:8]  = rx_data;
                            default: wbuf_n[23:16] = rx_data;
                        endcase
                        byte_idx_n = byte_idx + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                // Compare in 32 bits: word_idx+1 can equal DEPTH, which does
                // not fit in WW bits.
                if (32'(word_idx) + 32'd1 == {16'd0, count}) begin
                    state_n = S_DONE;
                end else begin
                    word_idx_n = word_idx + 1'b1;
                    state_n    = S_DATA;
                end
            end
            S_DONE: begin
                done_n     = 1'b1;
                busy_n     = 1'b0;
                cpu_hold_n = 1'b0;
                state_n    = S_IDLE;
            end
            S_ERR: begin
                error_n    = 1'b1;
                busy_n     = 1'b0;
                cpu_hold_n = 1'b0;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a stream-level reference model
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          ws_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            ws_q.push_back(cyc);
        end
    end

    logic [7:0]  stream[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic        exp_done;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // The whole session outcome follows from the stream: the header gives the
    // word count, then words are consecutive 4-byte little-endian groups.
    task automatic build_model();
        int n;
        exp_a.delete();
        exp_d.delete();
        n = int'(stream[0]) + 256 * int'(stream[1]);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n > 1024) begin
            exp_err = 1'b1;
        end else begin
            exp_done = 1'b1;
            for (int w = 0; w < n; w++) begin
                exp_a.push_back(32'(4 * w));
                exp_d.push_back({stream[2+4*w+3], stream[2+4*w+2],
                                 stream[2+4*w+1], stream[2+4*w]});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            start    = pulse_start && ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        start    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 last_acc = cyc;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
        ws_q.delete();
    endtask

    task automatic run_session(input string name, input int gapmax, input bit pulses);
        int t;
        clear_writes();
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ":busy_start"}, 32'(busy), 32'd1);
        chk({name, ":hold_start"}, 32'(cpu_hold), 32'd1);
        chk({name, ":done_clr"}, 32'(done), 32'd0);
        chk({name, ":err_clr"}, 32'(error), 32'd0);
        foreach (stream[i])
            send_byte(stream[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, pulses);
        @(negedge clk);
        rx_valid = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({name, ":busy_end"}, 32'(busy), 32'd0);
        chk({name, ":hold_end"}, 32'(cpu_hold), 32'd0);
        chk({name, ":done"}, 32'(done), 32'(exp_done));
        chk({name, ":error"}, 32'(error), 32'(exp_err));
        chk({name, ":nwrites"}, 32'(wa_q.size()), 32'(exp_a.size()));
        foreach (exp_a[i]) begin
            if (i < wa_q.size()) begin
                chk({name, ":addr"}, wa_q[i], exp_a[i]);
                chk({name, ":data"}, wd_q[i], exp_d[i]);
            end
        end
    endtask

    task automatic load_test2();
        stream = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, ":rx_ready"}, 32'(rx_ready), 32'd0);
        chk({name, ":mem_we"}, 32'(mem_we), 32'd0);
        chk({name, ":mem_addr"}, mem_addr, 32'd0);
        chk({name, ":mem_wdata"}, mem_wdata, 32'd0);
        chk({name, ":cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({name, ":busy"}, 32'(busy), 32'd0);
        chk({name, ":done"}, 32'(done), 32'd0);
        chk({name, ":error"}, 32'(error), 32'd0);
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("reset:no_we", 32'(wa_q.size()), 32'd0);

        // 2: two-word load, back-to-back, with strobe latency
        load_test2();
        run_session("t2", 0, 1'b0);
        if (ws_q.size() > 0) chk("t2:we_latency", 32'(ws_q[ws_q.size()-1]), 32'(last_acc));

        // 3: zero-length session, done two cycles after the second byte
        stream = '{8'h00, 8'h00};
        clear_writes();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t3:done_early", 32'(done), 32'd0);
        chk("t3:busy_mid", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t3:done", 32'(done), 32'd1);
        chk("t3:busy", 32'(busy), 32'd0);
        chk("t3:nwrites", 32'(wa_q.size()), 32'd0);

        // 4: one word over capacity
        stream = '{8'h01, 8'h04};
        run_session("t4", 0, 1'b0);

        // 5: test-2 stream with random gaps and ignored start pulses
        load_test2();
        run_session("t5", 4, 1'b1);

        // random streams under the same conditions
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(1, 4));
            stream.delete();
            stream.push_back(8'(n));
            stream.push_back(8'h00);
            for (int j = 0; j < 4 * n; j++) stream.push_back(8'($urandom));
            run_session("rand", 3, 1'b1);
        end

        // random oversize count
        n = int'($urandom_range(1025, 65535));
        stream = '{8'(n), 8'(n >> 8)};
        run_session("rand_err", 2, 1'b1);

        // full capacity: last word lands at byte address 0xFFC
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h04);
        for (int j = 0; j < 4096; j++) stream.push_back(8'($urandom));
        run_session("full", 0, 1'b0);

        // 6: reset after the 6th byte, start held with reset, then reload
        load_test2();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 6; j++) send_byte(stream[j], 0, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1 clear_writes();
        @(negedge clk);
        start = 1'b0;
        check_idle_outputs("t6_reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6:no_we", 32'(wa_q.size()), 32'd0);
        chk("t6:busy_idle", 32'(busy), 32'd0);
        run_session("t6", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
